// File: rtl/cjg_stack_ctrl_pkg.sv
// Shared definitions for the stack controller: request opcodes, requester ids,
// FSM state encoding and the arbiter grant record.
package cjg_stack_ctrl_pkg;

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   localparam logic SRC_CPU = 1'b0;
   localparam logic SRC_IRQ = 1'b1;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_POP_WAIT = 1'b1
   } stack_state_t;

   // One winner per cycle; src tells which requester's op/data to use
   typedef struct packed {
      logic valid;
      logic src;
   } grant_t;

endpackage

// File: rtl/cjg_stack_ctrl_if.sv
// Request, response and RAM-side buses of the stack controller.
// The slave modport is the controller; the master modport is its environment.
interface cjg_stack_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int ADDRW = 5
);

   logic             cpu_req_valid;
   logic             cpu_req_op;
   logic [WIDTH-1:0] cpu_req_data;
   logic             cpu_req_ready;

   logic             irq_req_valid;
   logic             irq_req_op;
   logic [WIDTH-1:0] irq_req_data;
   logic             irq_req_ready;

   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_src;

   logic [ADDRW-1:0] mem_addr;
   logic [WIDTH-1:0] mem_d;
   logic             mem_push;
   logic             mem_pop;
   logic [WIDTH-1:0] mem_q;

   modport slave (
      input  cpu_req_valid, cpu_req_op, cpu_req_data,
      input  irq_req_valid, irq_req_op, irq_req_data,
      input  mem_q,
      output cpu_req_ready, irq_req_ready,
      output rsp_valid, rsp_data, rsp_src,
      output mem_addr, mem_d, mem_push, mem_pop
   );

   modport master (
      output cpu_req_valid, cpu_req_op, cpu_req_data,
      output irq_req_valid, irq_req_op, irq_req_data,
      output mem_q,
      input  cpu_req_ready, irq_req_ready,
      input  rsp_valid, rsp_data, rsp_src,
      input  mem_addr, mem_d, mem_push, mem_pop
   );

endinterface

// File: rtl/cjg_stack_ctrl_arb.sv
// Two-way fixed-priority arbiter: the interrupt requester always beats the CPU.
// A merely pending IRQ request holds off the CPU even if the IRQ is not yet accepted.
module cjg_stack_ctrl_arb
   import cjg_stack_ctrl_pkg::*;
(
   input  logic   idle,
   input  logic   flush,
   input  logic   cpu_valid,
   input  logic   irq_valid,
   output logic   cpu_ready,
   output logic   irq_ready,
   output grant_t grant
);

   always_comb begin
      irq_ready = idle & ~flush;
      cpu_ready = idle & ~flush & ~irq_valid;
      grant     = '{valid: 1'b0, src: SRC_CPU};
      if (irq_valid && irq_ready) begin
         grant = '{valid: 1'b1, src: SRC_IRQ};
      end else if (cpu_valid && cpu_ready) begin
         grant = '{valid: 1'b1, src: SRC_CPU};
      end
   end

endmodule

// File: rtl/cjg_stack_ctrl.sv
// Stack controller: owns the stack pointer in front of a registered-read stack RAM,
// arbitrates CPU and IRQ push/pop requests and returns pop data one cycle later.
module cjg_stack_ctrl
   import cjg_stack_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32,
   parameter int ADDRW = 5
) (
   input  logic             clk,
   input  logic             reset,
   cjg_stack_ctrl_if.slave  bus,
   input  logic             flush,
   input  logic             err_clr,
   output logic [ADDRW:0]   sp,
   output logic             full,
   output logic             empty,
   output logic             overflow,
   output logic             underflow,
   input  logic             scan_in0,
   input  logic             scan_en,
   input  logic             test_mode,
   output logic             scan_out0
);

   localparam logic [ADDRW:0] SP_FULL = (ADDRW + 1)'(DEPTH);

   stack_state_t     state_q, state_d;
   logic [ADDRW:0]   sp_q, sp_d, sp_m1;
   logic             pop_src_q, pop_src_d;
   logic             pop_empty_q, pop_empty_d;
   logic [WIDTH-1:0] rsp_hold_q;
   logic             overflow_q, underflow_q;
   logic             ovf_set, unf_set;
   grant_t           grant;
   logic             req_op;
   logic [WIDTH-1:0] req_data;
   logic             unused_dft;

   assign unused_dft = ^{scan_in0, scan_en, test_mode};
   assign scan_out0  = 1'b0;

   assign sp        = sp_q;
   assign full      = (sp_q == SP_FULL);
   assign empty     = (sp_q == '0);
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign sp_m1     = sp_q - 1'b1;

   cjg_stack_ctrl_arb u_arb (
      .idle      (state_q == ST_IDLE),
      .flush     (flush),
      .cpu_valid (bus.cpu_req_valid),
      .irq_valid (bus.irq_req_valid),
      .cpu_ready (bus.cpu_req_ready),
      .irq_ready (bus.irq_req_ready),
      .grant     (grant)
   );

   always_comb begin
      req_op   = bus.cpu_req_op;
      req_data = bus.cpu_req_data;
      if (grant.src == SRC_IRQ) begin
         req_op   = bus.irq_req_op;
         req_data = bus.irq_req_data;
      end
   end

   // Next-state and RAM strobes; the RAM side is driven straight from the accept
   always_comb begin
      state_d      = state_q;
      sp_d         = sp_q;
      pop_src_d    = pop_src_q;
      pop_empty_d  = pop_empty_q;
      ovf_set      = 1'b0;
      unf_set      = 1'b0;
      bus.mem_addr = '0;
      bus.mem_d    = '0;
      bus.mem_push = 1'b0;
      bus.mem_pop  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant.valid) begin
               if (req_op == OP_PUSH) begin
                  if (!full) begin
                     bus.mem_addr = sp_q[ADDRW-1:0];
                     bus.mem_d    = req_data;
                     bus.mem_push = 1'b1;
                     sp_d         = sp_q + 1'b1;
                  end else begin
                     ovf_set = 1'b1;
                  end
               end else begin
                  state_d   = ST_POP_WAIT;
                  pop_src_d = grant.src;
                  if (!empty) begin
                     bus.mem_addr = sp_m1[ADDRW-1:0];
                     bus.mem_pop  = 1'b1;
                     sp_d         = sp_m1;
                     pop_empty_d  = 1'b0;
                  end else begin
                     unf_set     = 1'b1;
                     pop_empty_d = 1'b1;
                  end
               end
            end
         end
         ST_POP_WAIT: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (flush) begin
         sp_d = '0;
      end
   end

   // An underflowing pop still answers, but with a zero word instead of stale RAM output
   assign bus.rsp_valid = (state_q == ST_POP_WAIT);
   assign bus.rsp_data  = bus.rsp_valid ? (pop_empty_q ? '0 : bus.mem_q) : rsp_hold_q;
   assign bus.rsp_src   = pop_src_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         sp_q        <= '0;
         pop_src_q   <= SRC_CPU;
         pop_empty_q <= 1'b0;
         rsp_hold_q  <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         pop_src_q   <= pop_src_d;
         pop_empty_q <= pop_empty_d;
         if (bus.rsp_valid) begin
            rsp_hold_q <= bus.rsp_data;
         end
         overflow_q  <= ovf_set | (overflow_q & ~err_clr);
         underflow_q <= unf_set | (underflow_q & ~err_clr);
      end
   end

endmodule

// File: tb/tb_cjg_stack_ctrl.sv
// Directed bench for cjg_stack_ctrl (DEPTH=4) with a registered-read stack RAM model
// and a response scoreboard fed at pop time and drained when rsp_valid appears.
module tb_cjg_stack_ctrl;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;
   localparam int ADDRW = 2;

   typedef struct {
      logic             src;
      logic [WIDTH-1:0] data;
   } rsp_t;

   logic clk;
   logic reset;
   logic flush;
   logic err_clr;
   logic [ADDRW:0] sp;
   logic full, empty, overflow, underflow;
   logic scan_in0, scan_en, test_mode, scan_out0;

   int checks;
   int failures;

   rsp_t             sb[$];
   int               model_sp;
   logic [WIDTH-1:0] model_mem [DEPTH];

   logic [WIDTH-1:0] ram [DEPTH];
   logic [WIDTH-1:0] ram_q;

   cjg_stack_ctrl_if #(.WIDTH(WIDTH), .ADDRW(ADDRW)) bus ();

   cjg_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .flush     (flush),
      .err_clr   (err_clr),
      .sp        (sp),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .underflow (underflow),
      .scan_in0  (scan_in0),
      .scan_en   (scan_en),
      .test_mode (test_mode),
      .scan_out0 (scan_out0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stack RAM stand-in: synchronous write, registered read
   always_ff @(posedge clk) begin
      if (bus.mem_push) begin
         ram[bus.mem_addr] <= bus.mem_d;
      end
      ram_q <= ram[bus.mem_addr];
   end
   assign bus.mem_q = ram_q;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic cv, input logic cop, input logic [WIDTH-1:0] cd,
                                input logic iv, input logic iop, input logic [WIDTH-1:0] id,
                                input logic fl, input logic ec);
      @(negedge clk);
      bus.cpu_req_valid = cv;
      bus.cpu_req_op    = cop;
      bus.cpu_req_data  = cd;
      bus.irq_req_valid = iv;
      bus.irq_req_op    = iop;
      bus.irq_req_data  = id;
      flush             = fl;
      err_clr           = ec;
   endtask

   task automatic idleStep();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Advance one edge, then drain the scoreboard if a response is on the bus
   task automatic tick();
      rsp_t e;
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
         checkOutput("rsp_expected_pending", 64'(sb.size() > 0), 64'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            checkOutput("rsp_src", 64'(bus.rsp_src), 64'(e.src));
         end
      end
   endtask

   task automatic doPush(input logic src, input logic [WIDTH-1:0] d, input logic ec);
      applyStimulus(src == 1'b0, 1'b1, d, src == 1'b1, 1'b1, d, 1'b0, ec);
      #1;
      if (model_sp < DEPTH) begin
         checkOutput("push_strobe", 64'(bus.mem_push), 64'd1);
         checkOutput("push_addr", 64'(bus.mem_addr), 64'(model_sp));
         checkOutput("push_data", 64'(bus.mem_d), 64'(d));
         model_mem[model_sp] = d;
         model_sp++;
      end else begin
         checkOutput("push_full_no_write", 64'(bus.mem_push), 64'd0);
      end
      tick();
      checkOutput("push_sp", 64'(sp), 64'(model_sp));
      checkOutput("push_no_rsp", 64'(bus.rsp_valid), 64'd0);
   endtask

   task automatic doPop(input logic src);
      rsp_t e;
      applyStimulus(src == 1'b0, 1'b0, '0, src == 1'b1, 1'b0, '0, 1'b0, 1'b0);
      #1;
      e.src = src;
      if (model_sp > 0) begin
         checkOutput("pop_strobe", 64'(bus.mem_pop), 64'd1);
         checkOutput("pop_addr", 64'(bus.mem_addr), 64'(model_sp - 1));
         model_sp--;
         e.data = model_mem[model_sp];
      end else begin
         checkOutput("pop_empty_no_strobe", 64'(bus.mem_pop), 64'd0);
         e.data = '0;
      end
      sb.push_back(e);
      tick();
      checkOutput("pop_rsp_latency", 64'(bus.rsp_valid), 64'd1);
      checkOutput("pop_sp", 64'(sp), 64'(model_sp));
      idleStep();
      tick();
      checkOutput("pop_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      model_sp = 0;
      reset    = 1'b0;
      flush    = 1'b0;
      err_clr  = 1'b0;
      scan_in0 = 1'b0;
      scan_en  = 1'b0;
      test_mode = 1'b0;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_op    = 1'b0;
      bus.cpu_req_data  = '0;
      bus.irq_req_valid = 1'b0;
      bus.irq_req_op    = 1'b0;
      bus.irq_req_data  = '0;

      repeat (2) @(negedge clk);
      checkOutput("rst_sp", 64'(sp), 64'd0);
      checkOutput("rst_empty", 64'(empty), 64'd1);
      checkOutput("rst_full", 64'(full), 64'd0);
      checkOutput("rst_flags", 64'({overflow, underflow}), 64'd0);
      checkOutput("rst_rsp", 64'({bus.rsp_valid, bus.rsp_src, bus.rsp_data}), 64'd0);
      checkOutput("rst_mem", 64'({bus.mem_push, bus.mem_pop, bus.mem_addr}), 64'd0);
      checkOutput("scan_out0", 64'(scan_out0), 64'd0);
      reset = 1'b1;

      idleStep();
      #1;
      checkOutput("idle_cpu_ready", 64'(bus.cpu_req_ready), 64'd1);

      // Back-to-back CPU pushes, then two pops (LIFO)
      doPush(1'b0, 32'hA, 1'b0);
      doPush(1'b0, 32'hB, 1'b0);
      doPush(1'b0, 32'hC, 1'b0);
      doPop(1'b0);
      doPop(1'b0);
      checkOutput("after_pops_sp", 64'(sp), 64'd1);

      // Flush blocks requests and empties the stack
      applyStimulus(1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("flush_cpu_ready", 64'(bus.cpu_req_ready), 64'd0);
      checkOutput("flush_irq_ready", 64'(bus.irq_req_ready), 64'd0);
      checkOutput("flush_no_push", 64'(bus.mem_push), 64'd0);
      tick();
      model_sp = 0;
      checkOutput("flush_sp", 64'(sp), 64'd0);

      // Fill, then overflow; err_clr racing a new error keeps the flag
      for (int i = 1; i <= 5; i++) begin
         doPush(1'b0, WIDTH'(i), 1'b0);
      end
      checkOutput("ovf_flag", 64'(overflow), 64'd1);
      checkOutput("ovf_full", 64'(full), 64'd1);
      doPush(1'b0, 32'h66, 1'b1);
      checkOutput("ovf_set_wins", 64'(overflow), 64'd1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick();
      checkOutput("ovf_cleared", 64'(overflow), 64'd0);

      // Drain and pop once more on empty
      for (int i = 0; i < 4; i++) begin
         doPop(1'b0);
      end
      checkOutput("no_unf_yet", 64'(underflow), 64'd0);
      doPop(1'b0);
      checkOutput("unf_flag", 64'(underflow), 64'd1);
      checkOutput("unf_empty", 64'(empty), 64'd1);
      checkOutput("unf_rsp_hold", 64'(bus.rsp_data), 64'd0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick();
      checkOutput("unf_cleared", 64'(underflow), 64'd0);

      // Simultaneous CPU and IRQ push: IRQ first
      applyStimulus(1'b1, 1'b1, 32'h1, 1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
      #1;
      checkOutput("prio_irq_ready", 64'(bus.irq_req_ready), 64'd1);
      checkOutput("prio_cpu_ready", 64'(bus.cpu_req_ready), 64'd0);
      checkOutput("prio_addr0", 64'(bus.mem_addr), 64'd0);
      checkOutput("prio_data0", 64'(bus.mem_d), 64'h2);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      checkOutput("prio_addr1", 64'(bus.mem_addr), 64'd1);
      checkOutput("prio_data1", 64'(bus.mem_d), 64'h1);
      tick();
      checkOutput("prio_sp", 64'(sp), 64'd2);
      model_mem[0] = 32'h2;
      model_mem[1] = 32'h1;
      model_sp     = 2;
      doPop(1'b1);

      // Flush during POP_WAIT: response still issued, sp cleared
      doPush(1'b0, 32'h77, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      model_sp--;
      sb.push_back('{src: 1'b0, data: 32'h77});
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      checkOutput("flush_pw_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("flush_pw_rsp_data", 64'(bus.rsp_data), 64'h77);
      tick();
      model_sp = 0;
      checkOutput("flush_pw_sp", 64'(sp), 64'd0);
      checkOutput("flush_pw_flags", 64'({overflow, underflow}), 64'd0);

      // Async reset during POP_WAIT drops the response
      doPush(1'b0, 32'h99, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      checkOutput("rst_pw_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_pw_sp", 64'(sp), 64'd0);
      checkOutput("rst_pw_rsp_data", 64'(bus.rsp_data), 64'd0);
      model_sp = 0;
      idleStep();
      reset = 1'b1;
      tick();
      checkOutput("rst_pw_quiet", 64'(bus.rsp_valid), 64'd0);

      checkOutput("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
